// File: rtl/shifter_operand_pipe_pkg.sv
// shifter_operand_pipe_pkg: shared encodings, field positions and pipeline payload types
package shifter_operand_pipe_pkg;
  typedef enum logic [1:0] {SH_LSL = 2'd0, SH_LSR = 2'd1, SH_ASR = 2'd2, SH_ROR = 2'd3} shift_t;
  localparam logic [2:0] CLS_DP_REG = 3'b000;
  localparam logic [2:0] CLS_DP_IMM = 3'b001;
  localparam logic [2:0] CLS_LS_IMM = 3'b010;
  localparam logic [2:0] CLS_LS_REG = 3'b011;
  localparam logic [2:0] CLS_BRANCH = 3'b101;
  localparam int CLS_LSB       = 25;
  localparam int ROT_LSB       = 8;
  localparam int SH_AMT_LSB    = 7;
  localparam int SH_TYPE_LSB   = 5;
  localparam int REG_SHIFT_BIT = 4;
  typedef struct packed {
    logic [31:0] data;
    shift_t      sh;
    logic [5:0]  amt;
    logic        cin;
  } op_t;
  typedef struct packed {
    logic        carry;
    logic [31:0] value;
  } res_t;
endpackage

// File: rtl/shifter_operand_pipe_if.sv
// shifter_operand_pipe_if: input/output handshake and operand bus of the operand pipe
interface shifter_operand_pipe_if;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rm;
  logic [31:0] rs;
  logic        carry_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] operand;
  logic        carry_out;
  modport master (output flush, in_valid, instr, rm, rs, carry_in, out_ready,
                  input  in_ready, out_valid, operand, carry_out);
  modport slave  (input  flush, in_valid, instr, rm, rs, carry_in, out_ready,
                  output in_ready, out_valid, operand, carry_out);
endinterface

// File: rtl/shifter_operand_pipe_barrel.sv
// barrel_shift32: combinational 32-bit shifter with carry-out, amounts 0..63 with register-shift semantics
module barrel_shift32
  import shifter_operand_pipe_pkg::*;
(
  input  logic [31:0] data_i,
  input  shift_t      type_i,
  input  logic [5:0]  amount_i,
  input  logic        carry_i,
  output logic [31:0] result_o,
  output logic        carry_o
);
  logic [32:0] lsl, lsr, asr;
  logic [31:0] ror;
  // Extra bit beside the data catches the last bit shifted out; amount 0 passes data and carry through
  always_comb begin
    lsl = {1'b0, data_i} << amount_i;
    lsr = {data_i, 1'b0} >> amount_i;
    asr = $signed({data_i, 1'b0}) >>> amount_i;
    ror = 32'({data_i, data_i} >> amount_i[4:0]);
    {carry_o, result_o} = amount_i == 6'd0  ? {carry_i, data_i} :
                          type_i == SH_LSL  ? lsl :
                          type_i == SH_LSR  ? {lsr[0], lsr[32:1]} :
                          type_i == SH_ASR  ? {asr[0], asr[32:1]} :
                                              {ror[31], ror};
  end
endmodule

// File: rtl/shifter_operand_pipe.sv
// shifter_operand_pipe: decodes operand B class, shifts it and returns value plus carry through a valid/ready pipe
module shifter_operand_pipe
  import shifter_operand_pipe_pkg::*;
#(
  parameter int STAGES      = 2,
  parameter int REGSHIFT_EN = 1,
  parameter int RRX_EN      = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  shifter_operand_pipe_if.slave bus
);
  logic [2:0]  cls;
  shift_t      t;
  logic [4:0]  n;
  logic [7:0]  a;
  logic        reg_form, imm_form;
  op_t         dec, bs_in;
  logic        bs_v, bs_c, adv_o, vo_q, vo_d;
  logic [31:0] bs_val;
  res_t        res_q, res_d;
  logic        unused_bits;
  assign cls         = bus.instr[CLS_LSB +: 3];
  assign t           = shift_t'(bus.instr[SH_TYPE_LSB +: 2]);
  assign a           = bus.rs[7:0];
  assign reg_form    = cls == CLS_DP_REG && bus.instr[REG_SHIFT_BIT] && REGSHIFT_EN != 0;
  assign imm_form    = (cls == CLS_DP_REG && !reg_form) || (cls == CLS_LS_REG && !bus.instr[REG_SHIFT_BIT]);
  assign n           = bus.instr[REG_SHIFT_BIT] ? 5'd0 : bus.instr[SH_AMT_LSB +: 5];
  assign unused_bits = ^{bus.rs[31:8], bus.instr[31:28]};
  // Reduce every class to data/type/amount/carry; non-shifting results are pre-formed and pass with amount 0
  always_comb begin
    dec = '{data: bus.rm, sh: t, amt: 6'd0, cin: bus.carry_in};
    if (cls == CLS_DP_IMM) begin
      dec.data = {24'd0, bus.instr[7:0]};
      dec.sh   = SH_ROR;
      dec.amt  = {1'b0, bus.instr[ROT_LSB +: 4], 1'b0};
    end else if (imm_form && t == SH_ROR && n == 5'd0) begin
      if (RRX_EN != 0) begin
        dec.data = {bus.carry_in, bus.rm[31:1]};
        dec.cin  = bus.rm[0];
      end
    end else if (imm_form)
      dec.amt = (n == 5'd0 && (t == SH_LSR || t == SH_ASR)) ? 6'd32 : {1'b0, n};
    else if (reg_form)
      dec.amt = t == SH_ROR ? {|a[7:5], a[4:0]} : |a[7:6] ? 6'd63 : a[5:0];
    else if (cls == CLS_LS_IMM)
      dec.data = {20'd0, bus.instr[11:0]};
    else if (cls == CLS_BRANCH)
      dec.data = {{6{bus.instr[23]}}, bus.instr[23:0], 2'b00};
    else
      dec.data = '0;
  end
  generate
    if (STAGES == 2) begin : g_two
      logic vm_q, vm_d, adv_m;
      op_t  op_q, op_d;
      assign adv_m        = !vm_q || adv_o;
      assign vm_d         = bus.flush ? 1'b0 : adv_m ? bus.in_valid : vm_q;
      assign op_d         = adv_m && bus.in_valid ? dec : op_q;
      assign bs_in        = op_q;
      assign bs_v         = vm_q;
      assign bus.in_ready = adv_m;
      // Decode stage register: holds the effective shift request until the shift stage takes it
      always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
          vm_q <= 1'b0;
          op_q <= '0;
        end else begin
          vm_q <= vm_d;
          op_q <= op_d;
        end
    end else if (STAGES == 1) begin : g_one
      assign bs_in        = dec;
      assign bs_v         = bus.in_valid;
      assign bus.in_ready = adv_o;
    end else begin : g_bad
      $error("shifter_operand_pipe: STAGES must be 1 or 2");
    end
  endgenerate
  barrel_shift32 u_shift (
    .data_i   (bs_in.data),
    .type_i   (bs_in.sh),
    .amount_i (bs_in.amt),
    .carry_i  (bs_in.cin),
    .result_o (bs_val),
    .carry_o  (bs_c)
  );
  assign adv_o = !vo_q || bus.out_ready;
  assign vo_d  = bus.flush ? 1'b0 : adv_o ? bs_v : vo_q;
  assign res_d = adv_o && bs_v ? '{carry: bs_c, value: bs_val} : res_q;
  // Output stage register: result stays frozen while the consumer stalls
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      vo_q  <= 1'b0;
      res_q <= '0;
    end else begin
      vo_q  <= vo_d;
      res_q <= res_d;
    end
  assign bus.out_valid = vo_q;
  assign bus.operand   = res_q.value;
  assign bus.carry_out = res_q.carry;
endmodule
